// File: rtl/mcpu6bit_pkg.sv
// Shared constants and types for the 6-bit CPU memory responder.
package mcpu6bit_pkg;

  localparam int DATA_W  = 6;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int IO_ADDR = 15;

  // Loader FSM encoding kept explicit so it can be matched against older netlists.
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } loader_state_t;

  // Advance the loader pointer; one extra bit so the end of the image is visible.
  function automatic logic [ADDR_W:0] ptr_inc(input logic [ADDR_W:0] p);
    return p + (ADDR_W + 1)'(1);
  endfunction

endpackage

// File: rtl/mcpu6bit_loader.sv
// Program loader: walks the memory from address 0 taking one word per
// valid/ready handshake until the last cell is written.
module mcpu6bit_loader
  import mcpu6bit_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_en,
  input  logic              i_load_valid,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_load_ready,
  output logic              o_load_done,
  output logic              o_idle,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data
);

  loader_state_t     r_state;
  logic [ADDR_W:0]   r_ptr;
  logic              r_done;

  logic              w_ready;
  logic              w_accept;
  logic              w_last;

  assign w_ready  = (r_state == LD_LOAD);
  assign w_accept = w_ready && i_load_valid;
  // The pointer only reaches DEPTH after the final word, at which point
  // the FSM is already in DONE and no longer ready, so it never wraps.
  assign w_last   = (r_ptr == (ADDR_W + 1)'(DEPTH - 1));

  // FSM, pointer and done flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LD_IDLE;
      r_ptr   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        LD_IDLE: begin
          if (i_load_en) begin
            r_state <= LD_LOAD;
            r_ptr   <= '0;
            r_done  <= 1'b0;
          end
        end
        LD_LOAD: begin
          if (w_accept) begin
            r_ptr <= ptr_inc(r_ptr);
          end
          if (w_accept && w_last) begin
            r_done  <= 1'b1;
            r_state <= i_load_en ? LD_DONE : LD_IDLE;
          end else if (!i_load_en) begin
            // Abandoned load: whatever was written so far stays in memory.
            r_state <= LD_IDLE;
          end
        end
        LD_DONE: begin
          if (!i_load_en) begin
            r_state <= LD_IDLE;
          end
        end
        default: begin
          r_state <= LD_IDLE;
        end
      endcase
    end
  end

  assign o_load_ready = w_ready;
  assign o_load_done  = r_done;
  assign o_idle       = (r_state == LD_IDLE);
  assign o_wr_en      = w_accept;
  assign o_wr_addr    = r_ptr[ADDR_W-1:0];
  assign o_wr_data    = i_load_data;

endmodule

// File: rtl/mcpu6bit_mem_responder.sv
// Memory-side responder for the phase-multiplexed 6-bit CPU bus:
// address latch, 16x6 register file, write-port arbitration between the
// loader and CPU stores, one output latch and the CPU reset register.
module mcpu6bit_mem_responder
  import mcpu6bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              we_n,
  output logic [DATA_W-1:0] data_out,
  output logic              cpu_rst,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [DATA_W-1:0] out_port
);

  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_out_port;
  logic              r_cpu_rst;

  logic              w_ld_idle;
  logic              w_ld_wr_en;
  logic [ADDR_W-1:0] w_ld_wr_addr;
  logic [DATA_W-1:0] w_ld_wr_data;
  logic              w_cpu_we;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_io_we;

  mcpu6bit_loader u_loader (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_load_en    (load_en),
    .i_load_valid (load_valid),
    .i_load_data  (load_data),
    .o_load_ready (load_ready),
    .o_load_done  (load_done),
    .o_idle       (w_ld_idle),
    .o_wr_en      (w_ld_wr_en),
    .o_wr_addr    (w_ld_wr_addr),
    .o_wr_data    (w_ld_wr_data)
  );

  // Latch the address at the end of the high phase; bus_in[5:4] carry no address.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_q <= '0;
    end else begin
      r_addr_q <= bus_in[ADDR_W-1:0];
    end
  end

  // CPU stores only count while the loader is idle; otherwise the CPU is
  // held in reset and any stray we_n is meaningless.
  assign w_cpu_we = !we_n && w_ld_idle;

  // Single write port: the loader always wins over a CPU store.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_addr_q;
    w_mem_wdata = bus_in;
    if (w_ld_wr_en) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = w_ld_wr_addr;
      w_mem_wdata = w_ld_wr_data;
    end else if (w_cpu_we) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_addr_q;
      w_mem_wdata = bus_in;
    end
  end

  // Register file with clear-on-reset so an interrupted load leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Combinational read; addr_q is stable from the negedge to the next posedge.
  assign data_out = r_mem[r_addr_q];

  assign w_io_we = w_cpu_we && !w_ld_wr_en && (r_addr_q == ADDR_W'(IO_ADDR));

  // Memory-mapped output latch mirrors CPU stores to the IO address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_port <= '0;
    end else if (w_io_we) begin
      r_out_port <= bus_in;
    end
  end

  // CPU runs only when the loader is not requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_rst <= 1'b0;
    end else begin
      r_cpu_rst <= ~load_en;
    end
  end

  assign out_port = r_out_port;
  assign cpu_rst  = r_cpu_rst;

endmodule
